// File: rtl/pll_ctrl.sv
// pll_ctrl: sequences multiplier changes for a PLL that shares this block's reference clock.
// A change request raises bypass, waits for the clock to settle, loads the new multiplier,
// blanks the stale lock indication, and then waits (bounded) for lock before releasing bypass.
// After reset the controller waits for the initial lock in the same way, so io_done pulses once.
//
// Ports:
//   clock          reference clock (also the PLL reference)
//   reset_n        asynchronous active-low reset
//   io_req_valid   multiplier change request
//   io_req_mul     requested multiplier, captured on acceptance
//   io_req_ready   high only in IDLE
//   io_done        one-cycle completion pulse (high only in DONE)
//   io_error       last operation failed; held until the next accepted request
//   io_busy        high in any state other than IDLE
//   io_pll_mul     multiplier driven to the PLL
//   io_pll_bypass  PLL bypass select
//   io_pll_lock    PLL lock, asynchronous to clock
//
// Optional feature: define PLL_CTRL_LOSS_DETECT_EN to re-enter the lock wait when lock is
// lost for two consecutive cycles while idle and not bypassed.
module pll_ctrl #(
  parameter int unsigned RESET_MUL     = 1,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned BLANK_CYCLES  = 4,
  parameter int unsigned LOCK_TIMEOUT  = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       io_req_valid,
  input  logic [7:0] io_req_mul,
  output logic       io_req_ready,
  output logic       io_done,
  output logic       io_error,
  output logic       io_busy,
  output logic [7:0] io_pll_mul,
  output logic       io_pll_bypass,
  input  logic       io_pll_lock
);

  typedef enum logic [2:0] {
    BOOT, IDLE, SETTLE, BLANK, WAIT_LOCK, DONE
  } state_t;

  localparam logic [7:0]  RESET_MUL_V  = 8'(RESET_MUL);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] BLANK_LAST   = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic        lock_s;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  mul_q, mul_d;
  logic [7:0]  tgt_q, tgt_d;
  logic        bypass_q, bypass_d;
  logic        error_q, error_d;
`ifdef PLL_CTRL_LOSS_DETECT_EN
  logic        loss_q, loss_d;
`endif

  assign lock_s = sync_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= BOOT;
      sync_q   <= '0;
      cnt_q    <= '0;
      mul_q    <= RESET_MUL_V;
      tgt_q    <= '0;
      bypass_q <= 1'b1;
      error_q  <= 1'b0;
`ifdef PLL_CTRL_LOSS_DETECT_EN
      loss_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      mul_q    <= mul_d;
      tgt_q    <= tgt_d;
      bypass_q <= bypass_d;
      error_q  <= error_d;
`ifdef PLL_CTRL_LOSS_DETECT_EN
      loss_q   <= loss_d;
`endif
    end
  end

  // One counter is shared by SETTLE, BLANK and the lock wait; it is cleared on every entry.
  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[0], io_pll_lock};
    cnt_d    = cnt_q;
    mul_d    = mul_q;
    tgt_d    = tgt_q;
    bypass_d = bypass_q;
    error_d  = error_q;
`ifdef PLL_CTRL_LOSS_DETECT_EN
    loss_d   = 1'b0;
`endif
    unique case (state_q)
      BOOT, WAIT_LOCK: begin
        // Lock wins over a timeout landing on the same cycle.
        if (lock_s) begin
          bypass_d = 1'b0;
          state_d  = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      IDLE: begin
        if (io_req_valid) begin
          tgt_d = io_req_mul;
          cnt_d = '0;
          if (io_req_mul == '0) begin
            error_d = 1'b1;
            state_d = DONE;
          end else if (io_req_mul == mul_q && !bypass_q && lock_s) begin
            error_d = 1'b0;
            state_d = DONE;
          end else begin
            error_d  = 1'b0;
            bypass_d = 1'b1;
            if (SETTLE_CYCLES != 0) begin
              state_d = SETTLE;
            end else begin
              mul_d   = io_req_mul;
              state_d = (BLANK_CYCLES != 0) ? BLANK : WAIT_LOCK;
            end
          end
        end
`ifdef PLL_CTRL_LOSS_DETECT_EN
        else if (!bypass_q && !lock_s) begin
          // loss_q remembers that lock_s was already low on the previous idle cycle.
          if (loss_q) begin
            bypass_d = 1'b1;
            cnt_d    = '0;
            state_d  = WAIT_LOCK;
          end else begin
            loss_d = 1'b1;
          end
        end
`endif
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          mul_d   = tgt_q;
          state_d = (BLANK_CYCLES != 0) ? BLANK : WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BLANK: begin
        // lock_s here still reflects the previous multiplier and is deliberately not looked at.
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    io_req_ready  = (state_q == IDLE);
    io_busy       = (state_q != IDLE);
    io_done       = (state_q == DONE);
    io_error      = error_q;
    io_pll_mul    = mul_q;
    io_pll_bypass = bypass_q;
  end

endmodule

// File: tb/tb_pll_ctrl.sv
// Self-checking bench for pll_ctrl: a default instance driven by a behavioural PLL model,
// and a LOCK_TIMEOUT=16 instance whose lock input is tied low.
module tb_pll_ctrl;

  localparam int HMAX     = 128;
  localparam int LOCK_DLY = 8;

  typedef struct {
    int         lat;
    logic       err;
    logic       byp;
    logic [7:0] mul;
  } exp_t;

  exp_t sb[$];
  exp_t sb_to[$];
  int total = 0;
  int bad   = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic       reset_n, reset_to_n;
  logic       req_valid, to_req_valid;
  logic [7:0] req_mul, to_req_mul;
  logic       req_ready, done, error, busy, pll_bypass;
  logic [7:0] pll_mul;
  logic       to_req_ready, to_done, to_error, to_busy, to_pll_bypass;
  logic [7:0] to_pll_mul;
  logic       pll_lock = 1'b0;
  logic       to_lock;
  assign to_lock = 1'b0;

  pll_ctrl dut (
    .clock(clock), .reset_n(reset_n), .io_req_valid(req_valid), .io_req_mul(req_mul),
    .io_req_ready(req_ready), .io_done(done), .io_error(error), .io_busy(busy),
    .io_pll_mul(pll_mul), .io_pll_bypass(pll_bypass), .io_pll_lock(pll_lock)
  );

  pll_ctrl #(.LOCK_TIMEOUT(16)) dut_to (
    .clock(clock), .reset_n(reset_to_n), .io_req_valid(to_req_valid), .io_req_mul(to_req_mul),
    .io_req_ready(to_req_ready), .io_done(to_done), .io_error(to_error), .io_busy(to_busy),
    .io_pll_mul(to_pll_mul), .io_pll_bypass(to_pll_bypass), .io_pll_lock(to_lock)
  );

  // PLL model: lock asserts pll_delay falling edges after reset release or a multiplier change;
  // it is forced low for three cycles starting at cycle kill_start.
  int         pll_cnt    = 0;
  int         pll_delay  = 100;
  int         kill_start = -100;
  logic [7:0] prev_mul   = 8'd1;
  always @(negedge clock) begin
    if (!reset_n || (cyc >= kill_start && cyc < kill_start + 3) || (pll_mul !== prev_mul)) begin
      pll_cnt  <= 0;
      pll_lock <= 1'b0;
    end else begin
      pll_cnt  <= pll_cnt + 1;
      pll_lock <= (pll_cnt + 1 >= pll_delay);
    end
    prev_mul <= pll_mul;
  end

  // Per-cycle history: h_* for dut, g_* for dut_to. Index k=1 is the cycle observe() starts in.
  logic       h_done [1:HMAX];
  logic       h_err  [1:HMAX];
  logic       h_byp  [1:HMAX];
  logic       h_rdy  [1:HMAX];
  logic [7:0] h_mul  [1:HMAX];
  logic       g_done [1:HMAX];
  logic       g_err  [1:HMAX];
  logic       g_byp  [1:HMAX];
  logic [7:0] g_mul  [1:HMAX];

  task automatic observe(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      h_done[k] = done;    h_err[k] = error;    h_byp[k] = pll_bypass;
      h_rdy[k]  = req_ready; h_mul[k] = pll_mul;
      g_done[k] = to_done; g_err[k] = to_error; g_byp[k] = to_pll_bypass; g_mul[k] = to_pll_mul;
      @(posedge clock);
      #1;
    end
  endtask

  function automatic int first_done(input bit g, input int n);
    for (int k = 1; k <= n; k++)
      if ((g ? g_done[k] : h_done[k]) === 1'b1) return k;
    return 0;
  endfunction

  function automatic int n_done(input bit g, input int n);
    int c = 0;
    for (int k = 1; k <= n; k++)
      if ((g ? g_done[k] : h_done[k]) === 1'b1) c++;
    return c;
  endfunction

  function automatic int n_byp_not(input bit g, input int lo, input int hi, input logic v);
    int c = 0;
    for (int k = lo; k <= hi; k++)
      if ((g ? g_byp[k] : h_byp[k]) !== v) c++;
    return c;
  endfunction

  task automatic test_reset;
    exp_t e;
    int   fd;
    reset_n = 1'b0; reset_to_n = 1'b0;
    req_valid = 1'b0; req_mul = '0; to_req_valid = 1'b0; to_req_mul = '0;
    pll_delay = 100;
    repeat (3) @(posedge clock);
    #1;
    total++; if (pll_mul !== 8'd1) begin bad++; $display("FAIL rst_mul got=%0d exp=1", pll_mul); end
    total++; if (pll_bypass !== 1'b1) begin bad++; $display("FAIL rst_bypass got=%b exp=1", pll_bypass); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b exp=0", error); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", busy); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    reset_n = 1'b1; reset_to_n = 1'b1;
    // lock at the 100th falling edge (cycle R+99), two sync stages, then one cycle to DONE
    e.lat = 103; e.err = 1'b0; e.byp = 1'b0; e.mul = 8'd1; sb.push_back(e);
    // tied-low lock: counter 0..15 in BOOT, DONE on the 17th observed cycle
    e.lat = 17;  e.err = 1'b1; e.byp = 1'b1; e.mul = 8'd1; sb_to.push_back(e);
    observe(110);
    e = sb.pop_front();
    fd = first_done(1'b0, 110);
    total++; if (fd !== e.lat) begin bad++; $display("FAIL boot_done_cycle got=%0d exp=%0d", fd, e.lat); end
    total++; if (n_done(1'b0, 110) !== 1) begin bad++; $display("FAIL boot_done_count got=%0d exp=1", n_done(1'b0, 110)); end
    total++; if (n_byp_not(1'b0, 1, e.lat - 1, 1'b1) !== 0) begin bad++; $display("FAIL boot_bypass_held got=%0d exp=0 cycles low", n_byp_not(1'b0, 1, e.lat - 1, 1'b1)); end
    total++; if (h_byp[e.lat] !== e.byp) begin bad++; $display("FAIL boot_bypass_after got=%b exp=%b", h_byp[e.lat], e.byp); end
    total++; if (h_mul[110] !== e.mul) begin bad++; $display("FAIL boot_mul got=%0d exp=%0d", h_mul[110], e.mul); end
    total++; if (h_err[e.lat] !== e.err) begin bad++; $display("FAIL boot_error got=%b exp=%b", h_err[e.lat], e.err); end
    total++; if (h_rdy[110] !== 1'b1) begin bad++; $display("FAIL boot_ready got=%b exp=1", h_rdy[110]); end
    e = sb_to.pop_front();
    fd = first_done(1'b1, 110);
    total++; if (fd !== e.lat) begin bad++; $display("FAIL boot_timeout_cycle got=%0d exp=%0d", fd, e.lat); end
    total++; if (g_err[e.lat] !== e.err) begin bad++; $display("FAIL boot_timeout_error got=%b exp=%b", g_err[e.lat], e.err); end
    total++; if (g_byp[e.lat] !== e.byp) begin bad++; $display("FAIL boot_timeout_bypass got=%b exp=%b", g_byp[e.lat], e.byp); end
  endtask

  task automatic test_mul_change;
    exp_t e;
    int   fd;
    pll_delay = LOCK_DLY;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL chg_ready got=%b exp=1", req_ready); end
    req_valid = 1'b1; req_mul = 8'd8;
    // SETTLE T+1..T+2, BLANK T+3..T+6; PLL relocks LOCK_DLY edges after mul changes at T+3,
    // lock_s rises at T+5+LOCK_DLY, DONE one cycle later
    e.lat = 6 + LOCK_DLY; e.err = 1'b0; e.byp = 1'b0; e.mul = 8'd8; sb.push_back(e);
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_mul = 8'h55;
    observe(20);
    e = sb.pop_front();
    fd = first_done(1'b0, 20);
    total++; if (fd !== e.lat) begin bad++; $display("FAIL chg_done_cycle got=%0d exp=%0d", fd, e.lat); end
    total++; if (n_done(1'b0, 20) !== 1) begin bad++; $display("FAIL chg_done_count got=%0d exp=1", n_done(1'b0, 20)); end
    total++; if (n_byp_not(1'b0, 1, e.lat - 1, 1'b1) !== 0) begin bad++; $display("FAIL chg_bypass_high got=%0d exp=0 cycles low", n_byp_not(1'b0, 1, e.lat - 1, 1'b1)); end
    total++; if (h_byp[e.lat] !== e.byp) begin bad++; $display("FAIL chg_bypass_drop got=%b exp=%b", h_byp[e.lat], e.byp); end
    total++; if (h_mul[2] !== 8'd1) begin bad++; $display("FAIL chg_mul_settle got=%0d exp=1", h_mul[2]); end
    total++; if (h_mul[3] !== 8'd8) begin bad++; $display("FAIL chg_mul_load got=%0d exp=8", h_mul[3]); end
    total++; if (h_mul[20] !== e.mul) begin bad++; $display("FAIL chg_mul_final got=%0h exp=%0h", h_mul[20], e.mul); end
    total++; if (h_err[e.lat] !== e.err) begin bad++; $display("FAIL chg_error got=%b exp=%b", h_err[e.lat], e.err); end
  endtask

  task automatic test_zero_mul;
    exp_t e;
    req_valid = 1'b1; req_mul = 8'd0;
    e.lat = 1; e.err = 1'b1; e.byp = 1'b0; e.mul = 8'd8; sb.push_back(e);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    observe(4);
    e = sb.pop_front();
    total++; if (first_done(1'b0, 4) !== e.lat) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=%0d", first_done(1'b0, 4), e.lat); end
    total++; if (n_done(1'b0, 4) !== 1) begin bad++; $display("FAIL zero_done_count got=%0d exp=1", n_done(1'b0, 4)); end
    total++; if (h_err[e.lat] !== e.err) begin bad++; $display("FAIL zero_error got=%b exp=%b", h_err[e.lat], e.err); end
    total++; if (h_err[4] !== 1'b1) begin bad++; $display("FAIL zero_error_held got=%b exp=1", h_err[4]); end
    total++; if (n_byp_not(1'b0, 1, 4, e.byp) !== 0) begin bad++; $display("FAIL zero_bypass got=%0d exp=0 cycles high", n_byp_not(1'b0, 1, 4, e.byp)); end
    total++; if (h_mul[4] !== e.mul) begin bad++; $display("FAIL zero_mul got=%0d exp=%0d", h_mul[4], e.mul); end
  endtask

  task automatic test_same_mul;
    exp_t e;
    req_valid = 1'b1; req_mul = 8'd8;
    e.lat = 1; e.err = 1'b0; e.byp = 1'b0; e.mul = 8'd8; sb.push_back(e);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    observe(6);
    e = sb.pop_front();
    total++; if (first_done(1'b0, 6) !== e.lat) begin bad++; $display("FAIL same_done_cycle got=%0d exp=%0d", first_done(1'b0, 6), e.lat); end
    total++; if (n_done(1'b0, 6) !== 1) begin bad++; $display("FAIL same_done_count got=%0d exp=1", n_done(1'b0, 6)); end
    total++; if (h_err[e.lat] !== e.err) begin bad++; $display("FAIL same_error got=%b exp=%b", h_err[e.lat], e.err); end
    total++; if (n_byp_not(1'b0, 1, 6, e.byp) !== 0) begin bad++; $display("FAIL same_bypass got=%0d exp=0 cycles high", n_byp_not(1'b0, 1, 6, e.byp)); end
  endtask

  task automatic test_timeout;
    exp_t e;
    to_req_valid = 1'b1; to_req_mul = 8'd4;
    // 2 SETTLE + 4 BLANK + 16 WAIT_LOCK cycles, DONE on the next
    e.lat = 23; e.err = 1'b1; e.byp = 1'b1; e.mul = 8'd4; sb_to.push_back(e);
    @(posedge clock);
    #1;
    to_req_valid = 1'b0; to_req_mul = 8'd9;
    observe(26);
    e = sb_to.pop_front();
    total++; if (first_done(1'b1, 26) !== e.lat) begin bad++; $display("FAIL to_done_cycle got=%0d exp=%0d", first_done(1'b1, 26), e.lat); end
    total++; if (n_done(1'b1, 26) !== 1) begin bad++; $display("FAIL to_done_count got=%0d exp=1", n_done(1'b1, 26)); end
    total++; if (g_err[1] !== 1'b0) begin bad++; $display("FAIL to_error_cleared got=%b exp=0", g_err[1]); end
    total++; if (g_err[e.lat] !== e.err) begin bad++; $display("FAIL to_error got=%b exp=%b", g_err[e.lat], e.err); end
    total++; if (n_byp_not(1'b1, 1, 26, e.byp) !== 0) begin bad++; $display("FAIL to_bypass got=%0d exp=0 cycles low", n_byp_not(1'b1, 1, 26, e.byp)); end
    total++; if (g_mul[26] !== e.mul) begin bad++; $display("FAIL to_mul got=%0d exp=%0d", g_mul[26], e.mul); end
  endtask

  task automatic test_loss;
    exp_t e;
    kill_start = cyc;
    observe(20);
`ifdef PLL_CTRL_LOSS_DETECT_EN
    // lock_s low from k=3; second low idle cycle at k=4 -> bypass at k=5;
    // model relocks at k=11, lock_s at k=13, DONE at k=14
    e.lat = 14; e.err = 1'b0; e.byp = 1'b0; e.mul = 8'd8; sb.push_back(e);
    e = sb.pop_front();
    total++; if (first_done(1'b0, 20) !== e.lat) begin bad++; $display("FAIL loss_done_cycle got=%0d exp=%0d", first_done(1'b0, 20), e.lat); end
    total++; if (n_done(1'b0, 20) !== 1) begin bad++; $display("FAIL loss_done_count got=%0d exp=1", n_done(1'b0, 20)); end
    total++; if (h_byp[4] !== 1'b0) begin bad++; $display("FAIL loss_bypass_early got=%b exp=0", h_byp[4]); end
    total++; if (n_byp_not(1'b0, 5, e.lat - 1, 1'b1) !== 0) begin bad++; $display("FAIL loss_bypass_high got=%0d exp=0 cycles low", n_byp_not(1'b0, 5, e.lat - 1, 1'b1)); end
    total++; if (h_byp[e.lat] !== e.byp) begin bad++; $display("FAIL loss_bypass_drop got=%b exp=%b", h_byp[e.lat], e.byp); end
    total++; if (h_mul[e.lat] !== e.mul) begin bad++; $display("FAIL loss_mul got=%0d exp=%0d", h_mul[e.lat], e.mul); end
    total++; if (h_err[e.lat] !== e.err) begin bad++; $display("FAIL loss_error got=%b exp=%b", h_err[e.lat], e.err); end
`else
    total++; if (n_done(1'b0, 20) !== 0) begin bad++; $display("FAIL loss_no_done got=%0d exp=0", n_done(1'b0, 20)); end
    total++; if (n_byp_not(1'b0, 1, 20, 1'b0) !== 0) begin bad++; $display("FAIL loss_no_bypass got=%0d exp=0 cycles high", n_byp_not(1'b0, 1, 20, 1'b0)); end
    total++; if (h_rdy[20] !== 1'b1) begin bad++; $display("FAIL loss_ready got=%b exp=1", h_rdy[20]); end
`endif
  endtask

  task automatic test_reset_mid;
    exp_t e;
    req_valid = 1'b1; req_mul = 8'd2;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    observe(4);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (pll_mul !== 8'd1) begin bad++; $display("FAIL mid_rst_mul got=%0d exp=1", pll_mul); end
    total++; if (pll_bypass !== 1'b1) begin bad++; $display("FAIL mid_rst_bypass got=%b exp=1", pll_bypass); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_rst_busy got=%b exp=1", busy); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", req_ready); end
    @(posedge clock);
    #1;
    observe(3);
    total++; if (n_done(1'b0, 3) !== 0) begin bad++; $display("FAIL mid_rst_no_done got=%0d exp=0", n_done(1'b0, 3)); end
    pll_delay = 100;
    reset_n = 1'b1;
    e.lat = 103; e.err = 1'b0; e.byp = 1'b0; e.mul = 8'd1; sb.push_back(e);
    observe(110);
    e = sb.pop_front();
    total++; if (first_done(1'b0, 110) !== e.lat) begin bad++; $display("FAIL mid_boot_cycle got=%0d exp=%0d", first_done(1'b0, 110), e.lat); end
    total++; if (n_done(1'b0, 110) !== 1) begin bad++; $display("FAIL mid_boot_count got=%0d exp=1", n_done(1'b0, 110)); end
    total++; if (h_byp[110] !== e.byp) begin bad++; $display("FAIL mid_boot_bypass got=%b exp=%b", h_byp[110], e.byp); end
    total++; if (h_mul[110] !== e.mul) begin bad++; $display("FAIL mid_boot_mul got=%0d exp=%0d", h_mul[110], e.mul); end
  endtask

  initial begin
    test_reset;
    test_mul_change;
    test_zero_mul;
    test_same_mul;
    test_timeout;
    test_loss;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_ctrl.md
PLL_CTRL -- requirements
Module: pll_ctrl

Interface
REQ-001 SHALL have parameter RESET_MUL, default 1: multiplier driven to the PLL from reset.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: cycles in bypass before the multiplier changes.
REQ-003 SHALL have parameter BLANK_CYCLES, default 4: cycles after a multiplier change during which lock is ignored.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 1024: maximum cycles to wait for lock; 16-bit counter.
REQ-005 SHALL have port clock  input  1  reference clock; the same clock feeds the PLL reference.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port io_req_valid  input  1  multiplier change request.
REQ-008 SHALL have port io_req_mul  input  8  requested multiplier.
REQ-009 SHALL have port io_req_ready  output  1  controller can accept a request.
REQ-010 SHALL have port io_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port io_error  output  1  last operation failed; held until the next accepted request.
REQ-012 SHALL have port io_busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port io_pll_mul  output  8  multiplier to the PLL.
REQ-014 SHALL have port io_pll_bypass  output  1  PLL bypass select.
REQ-015 SHALL have port io_pll_lock  input  1  PLL lock, asynchronous to this block.

Function
REQ-016 SHALL pass io_pll_lock through a 2-flop synchronizer (lock_s); all decisions SHALL use lock_s.
REQ-017 SHALL implement states BOOT, IDLE, SETTLE, BLANK, WAIT_LOCK, DONE.
REQ-018 SHALL drive io_req_ready=1 only in IDLE; a request is accepted on the cycle where valid and ready are both high.
REQ-019 On acceptance with mul==0: no PLL change; DONE the next cycle, with io_done=1 and io_error=1.
REQ-020 On acceptance with mul==io_pll_mul, bypass=0 and lock_s=1: DONE the next cycle, with io_done=1, io_error=0 and no bypass.
REQ-021 Otherwise the controller SHALL perform, in order:
- raise io_pll_bypass the cycle after acceptance;
- SETTLE for SETTLE_CYCLES cycles;
- load io_pll_mul on SETTLE exit;
- BLANK for BLANK_CYCLES cycles;
- enter WAIT_LOCK.
REQ-022 In WAIT_LOCK the timeout counter SHALL increment each cycle; lock_s=1 drops bypass and enters DONE with io_done=1 on the next cycle.
REQ-023 If the counter reaches LOCK_TIMEOUT before lock: DONE with io_error=1, io_pll_bypass held at 1 and io_pll_mul unchanged.
REQ-024 DONE SHALL last one cycle, then return to IDLE; io_done SHALL be high only in DONE.
REQ-025 io_req_mul SHALL be captured at acceptance; later changes to it are ignored.
REQ-026 A lock_s=1 seen during BLANK SHALL be ignored (stale lock from the previous multiplier).
REQ-027 SETTLE_CYCLES=0 or BLANK_CYCLES=0 SHALL skip the corresponding state.

Reset
REQ-028 Asserting reset_n low SHALL asynchronously force:
- state=BOOT, io_pll_mul=RESET_MUL, io_pll_bypass=1;
- io_done=0, io_error=0, io_busy=1, io_req_ready=0;
- synchronizer and counters cleared.
REQ-029 BOOT SHALL behave as WAIT_LOCK, including the timeout; exit SHALL go through DONE, so io_done pulses once after reset.
REQ-030 Reset asserted mid-sequence SHALL abandon the sequence; no io_done is produced for it.

Configuration
REQ-031 With macro PLL_CTRL_LOSS_DETECT_EN defined:
- in IDLE with bypass=0, lock_s low for 2 consecutive cycles SHALL raise bypass and enter WAIT_LOCK with the same multiplier;
- the resulting DONE SHALL pulse io_done;
- io_error SHALL be set on timeout.
REQ-032 Without PLL_CTRL_LOSS_DETECT_EN, lock_s SHALL be ignored in IDLE.

Verification
REQ-033 Reset release, PLL model locks after 100 ref edges -> bypass=1 throughout; one io_done; then bypass=0, io_pll_mul=1, io_req_ready=1.
REQ-034 Request mul=8 accepted at cycle T -> bypass=1 at T+1; io_pll_mul=8 at T+3; lock ignored T+3..T+6; bypass=0 one cycle after lock_s rises; single io_done.
REQ-035 Request mul=0 -> io_done and io_error high at T+1; io_pll_mul and bypass unchanged.
REQ-036 Request mul=4 with the PLL lock input tied 0, LOCK_TIMEOUT=16 -> io_error=1 and io_done 23 cycles after acceptance; bypass stays 1; io_pll_mul=4.
REQ-037 Repeat the request mul=8 while locked -> io_done at T+1; bypass never toggles.
REQ-038 With PLL_CTRL_LOSS_DETECT_EN, drop lock for 3 cycles in IDLE -> bypass rises, relock, io_done pulses once; without the macro -> no reaction.
